// File: rtl/csram_loader.sv
// CSRAM row loader: packs IN_WIDTH-bit words into WIDTH-bit rows and writes NUM_NEURONS rows.
// Optional trailing XOR checksum word is enabled by defining CSRAM_LOADER_CHECKSUM_EN.
module csram_loader #(
    parameter int NUM_NEURONS = 256,
    parameter int WIDTH       = 367,
    parameter int IN_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [IN_WIDTH-1:0]            in_data,
    output logic                           in_ready,
    output logic                           csram_wen,
    output logic [$clog2(NUM_NEURONS)-1:0] csram_address,
    output logic [WIDTH-1:0]               csram_data,
    output logic                           busy,
    output logic                           done,
    output logic                           checksum_err
);
    localparam int WPR = (WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int AW  = $clog2(NUM_NEURONS);
    localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_NEURONS - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WPR - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
`ifdef CSRAM_LOADER_CHECKSUM_EN
        CHECK  = 3'd3,
`endif
        FINISH = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic           in_ready_q, wen_q, busy_q, done_q;
`ifdef CSRAM_LOADER_CHECKSUM_EN
    logic [IN_WIDTH-1:0] sum_q, sum_d;
    logic                err_q, err_d;
`endif

    // Next-state, row packing and checksum accumulation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        row_d   = row_q;
`ifdef CSRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    addr_d  = '0;
`ifdef CSRAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    // Bits of the last word that fall beyond WIDTH-1 have no target and are dropped
                    for (int b = 0; b < WIDTH; b++) begin
                        if (cnt_q == CW'(b / IN_WIDTH)) begin
                            row_d[b] = in_data[b % IN_WIDTH];
                        end else begin
                            row_d[b] = row_q[b];
                        end
                    end
`ifdef CSRAM_LOADER_CHECKSUM_EN
                    sum_d = sum_q ^ in_data;
`endif
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            WRITE: begin
                if (addr_q == LAST_ADDR) begin
`ifdef CSRAM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = FINISH;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = LOAD;
                end
            end
`ifdef CSRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (in_valid) begin
                    if (in_data != sum_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = FINISH;
                end else begin
                    state_d = CHECK;
                end
            end
`endif
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            row_q      <= '0;
            in_ready_q <= 1'b0;
            wen_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CSRAM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
`ifdef CSRAM_LOADER_CHECKSUM_EN
            in_ready_q <= (state_d == LOAD) || (state_d == CHECK);
            busy_q     <= (state_d == LOAD) || (state_d == WRITE) || (state_d == CHECK);
            sum_q      <= sum_d;
            err_q      <= err_d;
`else
            in_ready_q <= (state_d == LOAD);
            busy_q     <= (state_d == LOAD) || (state_d == WRITE);
`endif
            wen_q      <= (state_d == WRITE);
            done_q     <= (state_d == FINISH);
        end
    end

    assign in_ready      = in_ready_q;
    assign csram_wen     = wen_q;
    assign csram_address = addr_q;
    assign csram_data    = row_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef CSRAM_LOADER_CHECKSUM_EN
    assign checksum_err  = err_q;
`else
    assign checksum_err  = 1'b0;
`endif

endmodule

// File: doc/csram_loader.md
CSRAM_LOADER -- requirements
Module: csram_loader

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 256, meaning the number of CSRAM rows to program.
REQ-002 The block SHALL have parameter WIDTH, default 367, meaning the CSRAM row width in bits.
REQ-003 The block SHALL have parameter IN_WIDTH, default 32, meaning the input word width; WPR = ceil(WIDTH/IN_WIDTH) words per row (12 at defaults).
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on the rising edge.
REQ-005 Port rst, input, 1 bit: reset; SHALL be asynchronous and active-high.
REQ-006 Port start, input, 1 bit: begin a programming pass.
REQ-007 Port in_valid, input, 1 bit: in_data holds a valid word.
REQ-008 Port in_data, input, IN_WIDTH bits: configuration word.
REQ-009 Port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-010 Port csram_wen, output, 1 bit: the CSRAM write enable.
REQ-011 Port csram_address, output, $clog2(NUM_NEURONS) bits: the CSRAM row address.
REQ-012 Port csram_data, output, WIDTH bits: the CSRAM write data.
REQ-013 Port busy, output, 1 bit: a pass is in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse when a pass completes.
REQ-015 Port checksum_err, output, 1 bit: the checksum mismatch flag.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WRITE, CHECK and FINISH.
REQ-017 IDLE: start=1 SHALL move to LOAD, clear the word counter, csram_address and checksum_err; start outside IDLE is ignored.
REQ-018 in_ready SHALL equal 1 only in LOAD and CHECK; a word is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-019 Word k (0-based) of a row SHALL land in row-buffer bits [k*IN_WIDTH +: IN_WIDTH]; bits of the last word beyond WIDTH-1 are discarded.
REQ-020 When word WPR-1 is accepted, the FSM SHALL go to WRITE, so csram_wen=1 in the next cycle, for exactly one cycle.
REQ-021 In WRITE, csram_data and csram_address SHALL be registered and stable for the whole cycle, covering the consumer's falling-edge write.
REQ-022 csram_wen SHALL be 0 in every state other than WRITE.
REQ-023 After WRITE on row NUM_NEURONS-1, the FSM SHALL go to CHECK if configured, else to FINISH; otherwise csram_address increments and the FSM returns to LOAD.
REQ-024 csram_address SHALL never wrap within a pass; it holds NUM_NEURONS-1 until the next start.
REQ-025 FINISH SHALL assert done for one cycle and then return to IDLE.
REQ-026 busy SHALL be 1 in LOAD, WRITE and CHECK, and 0 in IDLE and FINISH.
REQ-027 in_valid gaps SHALL only stall the pass, never corrupt it; word order is preserved.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE and clear counters, the row buffer and the checksum.
REQ-029 Under reset, all outputs SHALL be 0: in_ready, csram_wen, csram_address, csram_data, busy, done and checksum_err.
REQ-030 Reset mid-pass SHALL abandon the partial row with no write issued; rows already written are not rolled back.

Configuration
REQ-031 With macro CSRAM_LOADER_CHECKSUM_EN defined, the block SHALL XOR every accepted data word into a running IN_WIDTH-bit checksum.
REQ-032 With the macro defined, CHECK SHALL accept one trailing word and set checksum_err=1 if it differs from the checksum; the flag is sticky until start or reset.
REQ-033 With the macro defined, the block SHALL then go to FINISH.
REQ-034 Without the macro, the block SHALL have no CHECK state or checksum logic, and checksum_err SHALL be tied to 0.

Verification
REQ-035 Reset then start with NUM_NEURONS=4, WIDTH=40, IN_WIDTH=32, in_valid held at 1 -> exactly 4 wen pulses at addresses 0..3, each 3 cycles apart, and done 1 cycle after the last write.
REQ-036 Row words 0xDEADBEEF, 0x000000A5 -> csram_data = 40'hA5DEADBEEF; the upper 24 bits of word 1 are dropped.
REQ-037 in_valid toggled randomly through a full pass -> written data is identical to the contiguous-valid case, and wen is never high for 2 consecutive cycles.
REQ-038 rst pulsed after 1 word of row 2 -> outputs are 0 immediately, no write to address 2, and a new start reprograms from address 0.
REQ-039 Macro defined, trailing word equals the XOR of all words -> checksum_err=0 and done pulses; trailing word 0xFFFFFFFF mismatching -> checksum_err=1 held until the next start.
